// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: round-robin scheduler between two transaction sources and an I2C master core.
// Latency: the master sees m_start in the cycle after accept; the response pulse comes at least 3 cycles after m_start.
// Backpressure: reqN_ready is raised only in IDLE, for one requester at a time; responses are single-cycle pulses with no backpressure.
//
// Ports:
//   aclk, aresetn                     clock, asynchronous active-low reset
//   reqN_valid/ready/ctrl/wdata       transaction request from requester N (ctrl bit31: 1 = read, 0 = write)
//   rspN_valid/rdata/err              completion pulse to requester N; rdata/err hold until the next response
//   m_ctrl/m_wdata/m_start            command to the I2C master core
//   m_busy/m_rdata                    status and read data from the I2C master core
//   sched_busy                        high whenever the scheduler is not IDLE
module i2c_txn_scheduler #(
  parameter int unsigned BUSY_ACK_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 200000,
  parameter int unsigned TWR_CYCLES      = 500000
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_ctrl,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_ctrl,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,

  output logic [31:0] m_ctrl,
  output logic [31:0] m_wdata,
  output logic        m_start,
  input  logic        m_busy,
  input  logic [31:0] m_rdata,

  output logic        sched_busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;
  localparam logic [2:0] ST_TWR_HOLD  = 3'd5;

  localparam logic [31:0] BUSY_LIM = 32'(BUSY_ACK_CYCLES);
  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] TWR_LIM  = 32'(TWR_CYCLES);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] wdata_q, wdata_d;
  logic        txn_err_q, txn_err_d;
  logic [31:0] rsp0_rdata_q, rsp0_rdata_d;
  logic        rsp0_err_q, rsp0_err_d;
  logic [31:0] rsp1_rdata_q, rsp1_rdata_d;
  logic        rsp1_err_q, rsp1_err_d;

  logic        is_idle;
  logic        gnt_vld;
  logic        gnt_sel;
  logic        drive_cmd;
  logic [31:0] cnt_inc;
  logic        cap_vld;
  logic        cap_err;
  logic [31:0] cap_rdata;

  // Arbitration: a lone requester wins outright; on contention the one that
  // was not granted last time wins.
  assign is_idle = (state_q == ST_IDLE);
  assign gnt_vld = req0_valid | req1_valid;
  assign gnt_sel = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  assign req0_ready = is_idle & gnt_vld & ~gnt_sel;
  assign req1_ready = is_idle & gnt_vld &  gnt_sel;

  // The command stays on the master bus from ISSUE until the response is
  // delivered, so the master may sample it at any point of the transfer.
  assign drive_cmd = (state_q == ST_ISSUE) | (state_q == ST_WAIT_ACK) |
                     (state_q == ST_WAIT_DONE) | (state_q == ST_RESP);

  assign m_start    = (state_q == ST_ISSUE);
  assign m_ctrl     = drive_cmd ? ctrl_q  : 32'd0;
  assign m_wdata    = drive_cmd ? wdata_q : 32'd0;
  assign sched_busy = ~is_idle;

  assign rsp0_valid = (state_q == ST_RESP) & ~grant_q;
  assign rsp1_valid = (state_q == ST_RESP) &  grant_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign rsp1_err   = rsp1_err_q;

  // Counters stop at their limit: the limit test uses the incremented value,
  // so the count never passes the limit and cannot wrap.
  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ctrl_d       = ctrl_q;
    wdata_d      = wdata_q;
    txn_err_d    = txn_err_q;
    cap_vld      = 1'b0;
    cap_err      = 1'b0;
    cap_rdata    = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          grant_d      = gnt_sel;
          last_grant_d = gnt_sel;
          ctrl_d       = gnt_sel ? req1_ctrl  : req0_ctrl;
          wdata_d      = gnt_sel ? req1_wdata : req0_wdata;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = 32'd0;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (m_busy) begin
          cnt_d   = 32'd0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc >= BUSY_LIM) begin
          // Master never acknowledged the start: report an error.
          cnt_d   = BUSY_LIM;
          cap_vld = 1'b1;
          cap_err = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_DONE: begin
        if (!m_busy) begin
          cap_vld   = 1'b1;
          cap_rdata = m_rdata;
          state_d   = ST_RESP;
        end else if (cnt_inc >= TO_LIM) begin
          cnt_d   = TO_LIM;
          cap_vld = 1'b1;
          cap_err = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        cnt_d = 32'd0;
        // Only a successful write starts an EEPROM internal write cycle.
        if (!ctrl_q[31] && !txn_err_q && (TWR_LIM != 32'd0)) begin
          state_d = ST_TWR_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TWR_HOLD: begin
        if (cnt_inc >= TWR_LIM) begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        cnt_d   = 32'd0;
        state_d = ST_IDLE;
      end
    endcase

    if (cap_vld) begin
      txn_err_d = cap_err;
    end
  end

  // Response registers are per requester so each side keeps its own last
  // result until its next response.
  always_comb begin
    rsp0_rdata_d = rsp0_rdata_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_rdata_d = rsp1_rdata_q;
    rsp1_err_d   = rsp1_err_q;
    if (cap_vld) begin
      if (grant_q) begin
        rsp1_rdata_d = cap_rdata;
        rsp1_err_d   = cap_err;
      end else begin
        rsp0_rdata_d = cap_rdata;
        rsp0_err_d   = cap_err;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ctrl_q       <= 32'd0;
      wdata_q      <= 32'd0;
      txn_err_q    <= 1'b0;
      rsp0_rdata_q <= 32'd0;
      rsp0_err_q   <= 1'b0;
      rsp1_rdata_q <= 32'd0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ctrl_q       <= ctrl_d;
      wdata_q      <= wdata_d;
      txn_err_q    <= txn_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a behavioural I2C master busy model.
module tb_i2c_txn_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_ctrl = 32'd0;
  logic [31:0] req0_wdata = 32'd0;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        rsp0_err;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_ctrl = 32'd0;
  logic [31:0] req1_wdata = 32'd0;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rsp1_err;
  logic [31:0] m_ctrl;
  logic [31:0] m_wdata;
  logic        m_start;
  logic        m_busy = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        sched_busy;

  int total = 0;
  int bad = 0;

  // Busy model: mode 0 raises busy bm_dly cycles after start for bm_len
  // cycles, mode 1 never raises busy, mode 2 raises it and never drops it.
  int bm_mode = 0;
  int bm_dly = 2;
  int bm_len = 50;
  int bm_t = 0;
  bit bm_run = 1'b0;

  always #5 aclk = ~aclk;

  i2c_txn_scheduler #(
    .BUSY_ACK_CYCLES(16),
    .TIMEOUT_CYCLES (1000),
    .TWR_CYCLES     (100)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_ctrl  (req0_ctrl),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_ctrl  (req1_ctrl),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .m_ctrl     (m_ctrl),
    .m_wdata    (m_wdata),
    .m_start    (m_start),
    .m_busy     (m_busy),
    .m_rdata    (m_rdata),
    .sched_busy (sched_busy)
  );

  always @(negedge aclk) begin
    if (m_start) begin
      bm_run = 1'b1;
      bm_t   = 0;
    end else if (bm_run) begin
      bm_t++;
    end
    m_busy = bm_run && (bm_mode != 1) && (bm_t >= bm_dly) &&
             ((bm_mode == 2) || (bm_t < bm_dly + bm_len));
    if (bm_run && (bm_mode != 2) && (bm_t >= bm_dly + bm_len)) bm_run = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts negedges until the chosen requester sees its response pulse.
  task automatic wait_rsp(input int who, input int budget, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge aclk); #1;
      lat++;
      if ((who == 0 && rsp0_valid) || (who == 1 && rsp1_valid)) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_sched_busy got=%0b exp=0", sched_busy); end
    total++; if (m_start !== 1'b0) begin bad++; $display("FAIL reset_m_start got=%0b exp=0", m_start); end
    total++; if (m_ctrl !== 32'd0) begin bad++; $display("FAIL reset_m_ctrl got=%0h exp=0", m_ctrl); end
    total++; if (m_wdata !== 32'd0) begin bad++; $display("FAIL reset_m_wdata got=%0h exp=0", m_wdata); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b%0b exp=00", rsp0_valid, rsp1_valid); end
    total++; if (rsp0_rdata !== 32'd0 || rsp1_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%0h/%0h exp=0/0", rsp0_rdata, rsp1_rdata); end
    total++; if (rsp0_err !== 1'b0 || rsp1_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%0b%0b exp=00", rsp0_err, rsp1_err); end
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b%0b exp=00", req0_ready, req1_ready); end
    aresetn = 1'b1;
  endtask

  task automatic test_write_twr();
    int lat;
    bit seen;
    int hold;
    @(negedge aclk);
    bm_mode = 0; bm_dly = 2; bm_len = 50; m_rdata = 32'h0000_00A5;
    req0_ctrl = 32'h0000_A005; req0_wdata = 32'h0000_005A; req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL wr_accept_ready got=%0b%0b exp=10", req0_ready, req1_ready); end
    @(negedge aclk);
    req0_valid = 1'b0;
    #1;
    total++; if (m_start !== 1'b1) begin bad++; $display("FAIL wr_m_start got=%0b exp=1", m_start); end
    total++; if (m_ctrl !== 32'h0000_A005) begin bad++; $display("FAIL wr_m_ctrl got=%0h exp=a005", m_ctrl); end
    total++; if (m_wdata !== 32'h0000_005A) begin bad++; $display("FAIL wr_m_wdata got=%0h exp=5a", m_wdata); end
    total++; if (req0_ready !== 1'b0 || sched_busy !== 1'b1) begin bad++; $display("FAIL wr_issue_state ready=%0b busy=%0b exp ready=0 busy=1", req0_ready, sched_busy); end
    @(negedge aclk); #1;
    total++; if (m_start !== 1'b0) begin bad++; $display("FAIL wr_start_single got=%0b exp=0", m_start); end
    wait_rsp(0, 200, lat, seen);
    total++; if (!seen || lat != 52) begin bad++; $display("FAIL wr_rsp_latency seen=%0b lat=%0d exp seen=1 lat=52", seen, lat); end
    total++; if (rsp0_err !== 1'b0 || rsp0_rdata !== 32'h0000_00A5) begin bad++; $display("FAIL wr_rsp_data err=%0b rdata=%0h exp err=0 rdata=a5", rsp0_err, rsp0_rdata); end
    total++; if (m_ctrl !== 32'h0000_A005 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_held m_ctrl=%0h rsp1_valid=%0b exp a005/0", m_ctrl, rsp1_valid); end
    hold = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk); #1;
      if (!sched_busy) break;
      hold++;
    end
    total++; if (hold != 100) begin bad++; $display("FAIL wr_twr_hold got=%0d exp=100", hold); end
    total++; if (m_ctrl !== 32'd0 || m_wdata !== 32'd0) begin bad++; $display("FAIL wr_idle_cmd m_ctrl=%0h m_wdata=%0h exp 0/0", m_ctrl, m_wdata); end
    total++; if (rsp0_rdata !== 32'h0000_00A5 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_persist rdata=%0h valid=%0b exp a5/0", rsp0_rdata, rsp0_valid); end
  endtask

  task automatic test_round_robin();
    int lat;
    bit seen;
    @(negedge aclk);
    aresetn = 1'b0;
    bm_mode = 0; bm_dly = 2; bm_len = 5; m_rdata = 32'h11;
    req0_ctrl = 32'h8000_0001; req1_ctrl = 32'h8000_0002;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rr_first_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    wait_rsp(0, 100, lat, seen);
    total++; if (!seen || rsp0_rdata !== 32'h11 || rsp0_err !== 1'b0) begin bad++; $display("FAIL rr_rsp0 seen=%0b rdata=%0h err=%0b exp 1/11/0", seen, rsp0_rdata, rsp0_err); end
    m_rdata = 32'h22;
    @(negedge aclk); #1;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL rr_second_grant got=%0b%0b exp=01", req0_ready, req1_ready); end
    wait_rsp(1, 100, lat, seen);
    total++; if (!seen || rsp1_rdata !== 32'h22 || rsp1_err !== 1'b0) begin bad++; $display("FAIL rr_rsp1 seen=%0b rdata=%0h err=%0b exp 1/22/0", seen, rsp1_rdata, rsp1_err); end
    total++; if (rsp0_rdata !== 32'h11 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL rr_rsp0_hold rdata=%0h valid=%0b exp 11/0", rsp0_rdata, rsp0_valid); end
    m_rdata = 32'h33;
    @(negedge aclk); #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rr_third_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    @(negedge aclk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0, 100, lat, seen);
    total++; if (!seen || rsp0_rdata !== 32'h33) begin bad++; $display("FAIL rr_rsp0_again seen=%0b rdata=%0h exp 1/33", seen, rsp0_rdata); end
    @(negedge aclk);
  endtask

  task automatic test_ack_timeout();
    int lat;
    bit seen;
    @(negedge aclk);
    bm_mode = 1;
    req0_ctrl = 32'h0000_0003; req0_wdata = 32'h0000_0011; req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL ack_accept got=%0b exp=1", req0_ready); end
    @(negedge aclk);
    req0_valid = 1'b0;
    wait_rsp(0, 100, lat, seen);
    total++; if (!seen || lat != 17) begin bad++; $display("FAIL ack_latency seen=%0b lat=%0d exp seen=1 lat=17", seen, lat); end
    total++; if (rsp0_err !== 1'b1) begin bad++; $display("FAIL ack_err got=%0b exp=1", rsp0_err); end
    @(negedge aclk); #1;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL ack_no_twr sched_busy=%0b exp=0", sched_busy); end
    bm_mode = 0;
  endtask

  task automatic test_busy_timeout();
    int lat;
    bit seen;
    @(negedge aclk);
    bm_mode = 2; bm_dly = 2; m_rdata = 32'hDEAD_BEEF;
    req1_ctrl = 32'h8000_0010; req1_valid = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL to_accept got=%0b%0b exp=01", req0_ready, req1_ready); end
    @(negedge aclk);
    req1_valid = 1'b0;
    wait_rsp(1, 2000, lat, seen);
    total++; if (!seen || lat != 1003) begin bad++; $display("FAIL to_latency seen=%0b lat=%0d exp seen=1 lat=1003", seen, lat); end
    total++; if (rsp1_err !== 1'b1 || rsp1_rdata !== 32'd0) begin bad++; $display("FAIL to_rsp err=%0b rdata=%0h exp 1/0", rsp1_err, rsp1_rdata); end
    @(negedge aclk); #1;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL to_idle sched_busy=%0b exp=0", sched_busy); end
    bm_mode = 0;
  endtask

  task automatic test_hold_blocks();
    int lat;
    bit seen;
    int n;
    int rdy_hits;
    @(negedge aclk);
    bm_mode = 0; bm_dly = 2; bm_len = 5; m_rdata = 32'h44;
    req0_ctrl = 32'h0000_A006; req0_wdata = 32'h77; req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL hold_accept got=%0b exp=1", req0_ready); end
    @(negedge aclk);
    req0_valid = 1'b0;
    req1_ctrl = 32'h8000_0020; req1_valid = 1'b1;
    n = 0; rdy_hits = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk); #1;
      if (!sched_busy) break;
      n++;
      if (req1_ready) rdy_hits++;
    end
    total++; if (rdy_hits != 0) begin bad++; $display("FAIL hold_ready_leak got=%0d exp=0", rdy_hits); end
    total++; if (n != 108) begin bad++; $display("FAIL hold_busy_cycles got=%0d exp=108", n); end
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL hold_first_idle_grant got=%0b exp=1", req1_ready); end
    @(negedge aclk);
    req1_valid = 1'b0;
    wait_rsp(1, 100, lat, seen);
    total++; if (!seen || rsp1_rdata !== 32'h44 || rsp1_err !== 1'b0) begin bad++; $display("FAIL hold_rsp1 seen=%0b rdata=%0h err=%0b exp 1/44/0", seen, rsp1_rdata, rsp1_err); end
    @(negedge aclk);
  endtask

  task automatic test_reset_midflight();
    int lat;
    bit seen;
    int pulses;
    @(negedge aclk);
    bm_mode = 0; bm_dly = 2; bm_len = 50; m_rdata = 32'h99;
    req0_ctrl = 32'h8000_0005; req0_valid = 1'b1;
    @(negedge aclk);
    req0_valid = 1'b0;
    repeat (5) @(negedge aclk);
    #1;
    total++; if (sched_busy !== 1'b1 || m_ctrl !== 32'h8000_0005) begin bad++; $display("FAIL mid_inflight busy=%0b m_ctrl=%0h exp 1/80000005", sched_busy, m_ctrl); end
    aresetn = 1'b0;
    #1;
    total++; if (sched_busy !== 1'b0 || m_start !== 1'b0) begin bad++; $display("FAIL mid_reset_state busy=%0b start=%0b exp 0/0", sched_busy, m_start); end
    total++; if (m_ctrl !== 32'd0 || m_wdata !== 32'd0) begin bad++; $display("FAIL mid_reset_cmd m_ctrl=%0h m_wdata=%0h exp 0/0", m_ctrl, m_wdata); end
    total++; if (rsp1_rdata !== 32'd0 || rsp0_rdata !== 32'd0) begin bad++; $display("FAIL mid_reset_rdata got=%0h/%0h exp 0/0", rsp0_rdata, rsp1_rdata); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); #1;
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    aresetn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk); #1;
      if (rsp0_valid || rsp1_valid) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL mid_lost_rsp pulses=%0d exp=0", pulses); end
    @(negedge aclk);
    req0_ctrl = 32'h8000_0006; req1_ctrl = 32'h8000_0007;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL mid_first_grant got=%0b%0b exp=10", req0_ready, req1_ready); end
    @(negedge aclk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0, 200, lat, seen);
    total++; if (!seen || rsp0_rdata !== 32'h99) begin bad++; $display("FAIL mid_after_rsp seen=%0b rdata=%0h exp 1/99", seen, rsp0_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_twr();
    test_round_robin();
    test_ack_timeout();
    test_busy_timeout();
    test_hold_blocks();
    test_reset_midflight();
    repeat (3) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
